// File: rtl/fliq.sv
// fliq: FP immediate writeback queue.
// Buffers NaN-boxed FLI immediates with their destination register and drains
// them into the shared FP register-file write port whenever the FPU leaves the
// port idle. Reports RAW hazards on queued destinations to issue logic.
// Optional build macro FLIQ_FWD_EN adds per-query forwarding of the youngest
// matching queued immediate (FwdHit/FwdData ports).
module fliq #(
    parameter int unsigned FLEN  = 64,
    parameter int unsigned DEPTH = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              FliValid,
    output logic              FliReady,
    input  logic [FLEN-1:0]   Imm,
    input  logic [4:0]        FliRd,
    input  logic              FpuWe,
    input  logic              FlushQ,
    output logic              WbWe,
    output logic [4:0]        WbRd,
    output logic [FLEN-1:0]   WbData,
    input  logic [14:0]       QRs,
`ifdef FLIQ_FWD_EN
    output logic [2:0]        Hazard,
    output logic [2:0]        FwdHit,
    output logic [3*FLEN-1:0] FwdData
`else
    output logic [2:0]        Hazard
`endif
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [4:0]      rd_q  [DEPTH];
    logic [4:0]      rd_d  [DEPTH];
    logic [FLEN-1:0] imm_q [DEPTH];
    logic [FLEN-1:0] imm_d [DEPTH];
    logic [PW-1:0]   head_q, head_d;
    logic [PW-1:0]   tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;

    logic enq;
    logic deq;

    // Handshake and drain qualification; FPU ownership and flush block draining.
    always_comb begin
        FliReady = (count_q < CW'(DEPTH));
        enq      = FliValid & FliReady & ~FlushQ;
        deq      = (count_q != '0) & ~FpuWe & ~FlushQ;
        WbWe     = deq;
        WbRd     = rd_q[head_q];
        WbData   = imm_q[head_q];
    end

    // Next-state for slot storage, pointers and occupancy count.
    always_comb begin
        rd_d  = rd_q;
        imm_d = imm_q;
        if (enq) begin
            rd_d[tail_q]  = FliRd;
            imm_d[tail_q] = Imm;
        end
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (FlushQ) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (enq) tail_d = tail_q + PW'(1);
            if (deq) head_d = head_q + PW'(1);
            case ({enq, deq})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // State registers; reset clears the queue and all slot storage at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                rd_q[i]  <= '0;
                imm_q[i] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            rd_q    <= rd_d;
            imm_q   <= imm_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // RAW hazard per query slot: any valid entry whose Rd matches (f0 included).
    always_comb begin
        logic [PW-1:0] idx;
        Hazard = '0;
        idx    = '0;
        for (int unsigned s = 0; s < 3; s++) begin
            for (int unsigned age = 0; age < DEPTH; age++) begin
                idx = head_q + PW'(age);
                if ((CW'(age) < count_q) && (rd_q[idx] == QRs[s*5 +: 5]))
                    Hazard[s] = 1'b1;
            end
        end
    end

`ifdef FLIQ_FWD_EN
    // Forwarding: walk oldest to youngest so the youngest match wins.
    always_comb begin
        logic [PW-1:0] idx;
        FwdHit  = '0;
        FwdData = '0;
        idx     = '0;
        for (int unsigned s = 0; s < 3; s++) begin
            for (int unsigned age = 0; age < DEPTH; age++) begin
                idx = head_q + PW'(age);
                if ((CW'(age) < count_q) && (rd_q[idx] == QRs[s*5 +: 5])) begin
                    FwdHit[s]              = 1'b1;
                    FwdData[s*FLEN +: FLEN] = imm_q[idx];
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_fliq.sv
// Directed self-checking bench for fliq (FLEN=64, DEPTH=2).
module tb_fliq;

    localparam int unsigned FLEN = 64;

    logic              clk = 1'b0;
    logic              reset;
    logic              FliValid;
    logic              FliReady;
    logic [FLEN-1:0]   Imm;
    logic [4:0]        FliRd;
    logic              FpuWe;
    logic              FlushQ;
    logic              WbWe;
    logic [4:0]        WbRd;
    logic [FLEN-1:0]   WbData;
    logic [14:0]       QRs;
    logic [2:0]        Hazard;
`ifdef FLIQ_FWD_EN
    logic [2:0]        FwdHit;
    logic [3*FLEN-1:0] FwdData;
`endif

    int checks = 0;
    int errors = 0;

    localparam logic [63:0] IMM_ONE = 64'hFFFF_FFFF_3F80_0000;
    localparam logic [63:0] IMM_A   = 64'hFFFF_FFFF_AAAA_0001;
    localparam logic [63:0] IMM_B   = 64'hFFFF_FFFF_BBBB_0002;

    fliq #(.FLEN(FLEN), .DEPTH(2)) dut (
        .clk      (clk),
        .reset    (reset),
        .FliValid (FliValid),
        .FliReady (FliReady),
        .Imm      (Imm),
        .FliRd    (FliRd),
        .FpuWe    (FpuWe),
        .FlushQ   (FlushQ),
        .WbWe     (WbWe),
        .WbRd     (WbRd),
        .WbData   (WbData),
        .QRs      (QRs),
`ifdef FLIQ_FWD_EN
        .Hazard   (Hazard),
        .FwdHit   (FwdHit),
        .FwdData  (FwdData)
`else
        .Hazard   (Hazard)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs are driven 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [4:0] rd, input logic [63:0] imm);
        FliValid = 1'b1;
        FliRd    = rd;
        Imm      = imm;
    endtask

    initial begin
        reset = 1'b1; FliValid = 1'b0; Imm = '0; FliRd = '0;
        FpuWe = 1'b0; FlushQ = 1'b0; QRs = '0;
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        #1;
        // Reset state
        chk("rst_ready",  64'(FliReady), 64'd1);
        chk("rst_wbwe",   64'(WbWe),     64'd0);
        chk("rst_wbrd",   64'(WbRd),     64'd0);
        chk("rst_wbdata", WbData,        64'd0);
        chk("rst_hazard", 64'(Hazard),   64'd0);
        chk("rst_count",  64'(dut.count_q), 64'd0);
`ifdef FLIQ_FWD_EN
        chk("rst_fwdhit", 64'(FwdHit), 64'd0);
`endif

        // Basic drain: no same-cycle bypass, write one cycle later
        push(5'd5, IMM_ONE);
        #1;
        chk("drain_nobypass", 64'(WbWe), 64'd0);
        tick();
        FliValid = 1'b0;
        #1;
        chk("drain_we",   64'(WbWe), 64'd1);
        chk("drain_rd",   64'(WbRd), 64'd5);
        chk("drain_data", WbData,    IMM_ONE);
        tick(); #1;
        chk("drain_empty_we",    64'(WbWe),     64'd0);
        chk("drain_empty_ready", 64'(FliReady), 64'd1);
        chk("drain_empty_count", 64'(dut.count_q), 64'd0);

        // Port contention fills the queue
        FpuWe = 1'b1;
        push(5'd1, 64'h11);
        tick();
        push(5'd2, 64'h22);
        #1;
        chk("stall_we", 64'(WbWe), 64'd0);
        tick();
        push(5'd3, 64'h33);
        #1;
        chk("full_ready", 64'(FliReady), 64'd0);
        tick(); #1;
        chk("full_count", 64'(dut.count_q), 64'd2);
        // Full queue does not accept even while draining
        FpuWe = 1'b0;
        #1;
        chk("full_drain_ready", 64'(FliReady), 64'd0);
        chk("full_drain1_we",   64'(WbWe), 64'd1);
        chk("full_drain1_rd",   64'(WbRd), 64'd1);
        tick();
        FliValid = 1'b0;
        #1;
        chk("full_drain2_we",   64'(WbWe), 64'd1);
        chk("full_drain2_rd",   64'(WbRd), 64'd2);
        chk("full_drain2_data", WbData,    64'h22);
        tick(); #1;
        chk("full_no_rd3", 64'(WbWe), 64'd0);
        chk("full_count0", 64'(dut.count_q), 64'd0);

        // Simultaneous enqueue and dequeue
        push(5'd6, 64'h66);
        tick();
        push(5'd7, 64'h77);
        #1;
        chk("sim_we",    64'(WbWe),     64'd1);
        chk("sim_rd",    64'(WbRd),     64'd6);
        chk("sim_ready", 64'(FliReady), 64'd1);
        tick();
        FliValid = 1'b0;
        #1;
        chk("sim_count", 64'(dut.count_q), 64'd1);
        chk("sim_we2",   64'(WbWe), 64'd1);
        chk("sim_rd2",   64'(WbRd), 64'd7);
        chk("sim_data2", WbData,    64'h77);
        tick(); #1;
        chk("sim_count0", 64'(dut.count_q), 64'd0);

        // Flush with concurrent enqueue attempt
        FpuWe = 1'b1;
        push(5'd8, 64'h88);
        tick();
        push(5'd9, 64'h99);
        tick();
        FpuWe  = 1'b0;
        FlushQ = 1'b1;
        push(5'd10, 64'hAA);
        QRs = {5'd10, 5'd9, 5'd8};
        #1;
        chk("flush_we",     64'(WbWe),   64'd0);
        chk("flush_hz_pre", 64'(Hazard), 64'b011);
        tick();
        FlushQ   = 1'b0;
        FliValid = 1'b0;
        #1;
        chk("flush_count",  64'(dut.count_q), 64'd0);
        chk("flush_hazard", 64'(Hazard),   64'd0);
        chk("flush_we2",    64'(WbWe),     64'd0);
        chk("flush_ready",  64'(FliReady), 64'd1);
        tick(); #1;
        chk("flush_we3", 64'(WbWe), 64'd0);

        // Hazard / forwarding with duplicate destination
        FpuWe = 1'b1;
        push(5'd4, IMM_A);
        tick();
        push(5'd4, IMM_B);
        tick();
        FliValid = 1'b0;
        QRs = {5'd4, 5'd9, 5'd4};
        #1;
        chk("hz_101", 64'(Hazard), 64'b101);
`ifdef FLIQ_FWD_EN
        chk("fwd_hit",   64'(FwdHit),           64'b101);
        chk("fwd_slot0", FwdData[0*FLEN +: FLEN], IMM_B);
        chk("fwd_slot2", FwdData[2*FLEN +: FLEN], IMM_B);
`endif
        QRs = {5'd9, 5'd4, 5'd0};
        #1;
        chk("hz_010", 64'(Hazard), 64'b010);
        QRs = {5'd4, 5'd9, 5'd4};

        // Async reset mid-drain
        FpuWe = 1'b0;
        #1;
        chk("mid_we",   64'(WbWe), 64'd1);
        chk("mid_data", WbData,    IMM_A);
        reset = 1'b1;
        #1;
        chk("arst_we",     64'(WbWe),     64'd0);
        chk("arst_hazard", 64'(Hazard),   64'd0);
        chk("arst_count",  64'(dut.count_q), 64'd0);
        chk("arst_data",   WbData,        64'd0);
        chk("arst_ready",  64'(FliReady), 64'd1);
        reset = 1'b0;
        tick(); #1;
        chk("post_arst_we", 64'(WbWe), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
